// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
//
// Bus-master block copier that shares the data memory's read/write port with
// the core (the core-side mux selects this engine while `busy` is high).
// Elements of 1, 2 or 4 bytes are moved one at a time from an ascending
// source range to an ascending destination range, as a READ cycle followed
// by a WRITE cycle. The memory does lane select/insert, so sub-word data is
// kept right-justified in the data register.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   start               : one-cycle request, only honoured in IDLE
//   src_addr, dst_addr  : first source / destination byte address
//   length              : number of bytes to copy (LEN_W bits)
//   size                : 0 byte, 1 half-word, 2 word, 3 illegal
//   mem_write_mem       : write strobe, only high on a committing WRITE cycle
//   mem_funct3          : access size code (unsigned loads, store size in [1:0])
//   mem_write_address   : destination address of the current element
//   mem_write_data      : element captured by the preceding READ
//   mem_read_address    : source address of the current element
//   mem_read_data       : read return, valid at the posedge ending READ
//   mem_busy            : memory stall, holds the current access
//   busy                : engine owns the memory port (state != IDLE)
//   done / error        : one-cycle completion / rejection pulses
//   bytes_done          : bytes committed in the current or last transfer
// -----------------------------------------------------------------------------
module mem_copy_engine #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] length,
  input  logic [1:0]       size,
  output logic             mem_write_mem,
  output logic [2:0]       mem_funct3,
  output logic [31:0]      mem_write_address,
  output logic [31:0]      mem_write_data,
  output logic [31:0]      mem_read_address,
  input  logic [31:0]      mem_read_data,
  input  logic             mem_busy,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] bytes_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [31:0]      src_reg, src_next;
  logic [31:0]      dst_reg, dst_next;
  logic [31:0]      data_reg, data_next;
  logic [LEN_W-1:0] remaining_reg, remaining_next;
  logic [LEN_W-1:0] bytes_done_reg, bytes_done_next;
  logic [1:0]       size_reg, size_next;

  // Element width in bytes; size 3 never reaches the datapath because such
  // requests are rejected in IDLE.
  function automatic logic [2:0] elem_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Request validation: all three operands must be multiples of the element
  // size. The mask selects which low address/length bits must be zero.
  logic [1:0] align_mask;
  logic       request_bad;

  always_comb begin
    align_mask = 2'b00;
    case (size)
      2'd1:    align_mask = 2'b01;
      2'd2:    align_mask = 2'b11;
      default: align_mask = 2'b00;
    endcase
    request_bad = (size == 2'd3)
               || ((src_addr[1:0] & align_mask) != 2'b00)
               || ((dst_addr[1:0] & align_mask) != 2'b00)
               || ((length[1:0]   & align_mask) != 2'b00);
  end

  // Per-element step, in address and in length width.
  logic [2:0]       step_bytes;
  logic [31:0]      step_addr;
  logic [LEN_W-1:0] step_len;

  assign step_bytes = elem_bytes(size_reg);
  assign step_addr  = {29'd0, step_bytes};
  assign step_len   = LEN_W'(step_bytes);

  // Next-state and datapath updates. A stalled cycle leaves everything held,
  // which is what guarantees exactly one write per element.
  always_comb begin
    state_next      = state_reg;
    src_next        = src_reg;
    dst_next        = dst_reg;
    data_next       = data_reg;
    remaining_next  = remaining_reg;
    bytes_done_next = bytes_done_reg;
    size_next       = size_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (request_bad) begin
            state_next = S_ERR;
          end else if (length == '0) begin
            state_next = S_DONE;
          end else begin
            src_next        = src_addr;
            dst_next        = dst_addr;
            remaining_next  = length;
            size_next       = size;
            bytes_done_next = '0;
            state_next      = S_READ;
          end
        end
      end

      S_READ: begin
        if (!mem_busy) begin
          data_next  = mem_read_data;
          state_next = S_WRITE;
        end
      end

      S_WRITE: begin
        if (!mem_busy) begin
          src_next        = src_reg + step_addr;
          dst_next        = dst_reg + step_addr;
          remaining_next  = remaining_reg - step_len;
          bytes_done_next = bytes_done_reg + step_len;
          // Compare before the subtraction so the last element is detected
          // without waiting a cycle for remaining_reg to reach zero.
          if (remaining_reg == step_len) begin
            state_next = S_DONE;
          end else begin
            state_next = S_READ;
          end
        end
      end

      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      src_reg        <= '0;
      dst_reg        <= '0;
      data_reg       <= '0;
      remaining_reg  <= '0;
      bytes_done_reg <= '0;
      size_reg       <= 2'd2;
    end else begin
      state_reg      <= state_next;
      src_reg        <= src_next;
      dst_reg        <= dst_next;
      data_reg       <= data_next;
      remaining_reg  <= remaining_next;
      bytes_done_reg <= bytes_done_next;
      size_reg       <= size_next;
    end
  end

  // Access size code: unsigned byte/half loads so the right-justified data
  // carries no sign extension; stores only look at bits [1:0].
  always_comb begin
    mem_funct3 = 3'b010;
    if ((state_reg == S_READ) || (state_reg == S_WRITE)) begin
      case (size_reg)
        2'd0:    mem_funct3 = 3'b100;
        2'd1:    mem_funct3 = 3'b101;
        default: mem_funct3 = 3'b010;
      endcase
    end
  end

  // The strobe is gated by reset combinationally so an in-flight write cannot
  // commit on the same edge that returns the engine to IDLE.
  assign mem_write_mem     = (state_reg == S_WRITE) && !mem_busy && !reset;
  assign mem_write_address = dst_reg;
  assign mem_write_data    = data_reg;
  assign mem_read_address  = src_reg;

  assign busy       = (state_reg != S_IDLE);
  assign done       = (state_reg == S_DONE);
  assign error      = (state_reg == S_ERR);
  assign bytes_done = bytes_done_reg;

endmodule

// File: tb/tb_mem_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_engine
//
// Drives mem_copy_engine against a byte-addressed memory model (negedge read
// sample, posedge write commit, lane select/insert by funct3). Expected
// memory contents come from a separate byte-level reference image updated by
// a plain forward byte copy; timing expectations come from the element count
// and the number of stall cycles injected.
// -----------------------------------------------------------------------------
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] length;
  logic [1:0]  size;
  logic        mem_write_mem;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_write_address, mem_write_data, mem_read_address;
  logic [31:0] mem_read_data;
  logic        mem_busy;
  logic        busy, done, error;
  logic [15:0] bytes_done;

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;

  always #5 clk = ~clk;

  mem_copy_engine #(.LEN_W(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .src_addr         (src_addr),
    .dst_addr         (dst_addr),
    .length           (length),
    .size             (size),
    .mem_write_mem    (mem_write_mem),
    .mem_funct3       (mem_funct3),
    .mem_write_address(mem_write_address),
    .mem_write_data   (mem_write_data),
    .mem_read_address (mem_read_address),
    .mem_read_data    (mem_read_data),
    .mem_busy         (mem_busy),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .bytes_done       (bytes_done)
  );

  // ---------------- memory model and reference image ----------------------
  logic [7:0] mem     [bit [31:0]];
  logic [7:0] ref_mem [bit [31:0]];

  function automatic logic [7:0] mem_rd8(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd8(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] f3);
    case (f3)
      3'b100:  return {24'h0, mem_rd8(a)};
      3'b101:  return {16'h0, mem_rd8(a + 32'd1), mem_rd8(a)};
      default: return {mem_rd8(a + 32'd3), mem_rd8(a + 32'd2), mem_rd8(a + 32'd1), mem_rd8(a)};
    endcase
  endfunction

  function automatic logic [31:0] peek32(input logic [31:0] a);
    return {mem_rd8(a + 32'd3), mem_rd8(a + 32'd2), mem_rd8(a + 32'd1), mem_rd8(a)};
  endfunction

  task automatic poke32(input logic [31:0] a, input logic [31:0] d);
    for (int b = 0; b < 4; b++) begin
      mem[a + 32'(b)]     = d[8*b +: 8];
      ref_mem[a + 32'(b)] = d[8*b +: 8];
    end
  endtask

  always @(negedge clk) mem_read_data <= model_read(mem_read_address, mem_funct3);

  always @(posedge clk) begin
    if (mem_write_mem) begin
      wr_count++;
      mem[mem_write_address] = mem_write_data[7:0];
      if (mem_funct3[1:0] != 2'b00) mem[mem_write_address + 32'd1] = mem_write_data[15:8];
      if (mem_funct3[1:0] == 2'b10) begin
        mem[mem_write_address + 32'd2] = mem_write_data[23:16];
        mem[mem_write_address + 32'd3] = mem_write_data[31:24];
      end
    end
  end

  // ---------------- checking helpers --------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_mem(input string tag);
    int bad = 0;
    logic [31:0] first_a = '0;
    logic [7:0]  first_g = '0, first_e = '0;
    foreach (ref_mem[a]) begin
      if (mem_rd8(a) !== ref_mem[a]) begin
        if (bad == 0) begin first_a = a; first_g = mem_rd8(a); first_e = ref_mem[a]; end
        bad++;
      end
    end
    foreach (mem[a]) begin
      if (ref_rd8(a) !== mem[a]) begin
        if (bad == 0) begin first_a = a; first_g = mem[a]; first_e = ref_rd8(a); end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s.mem: %0d bytes differ, first at %h got %h expected %h",
               tag, bad, first_a, first_g, first_e);
    end
  endtask

  // Rejection rule straight from the operand constraints.
  function automatic logic rule_reject(input logic [31:0] s, input logic [31:0] d,
                                       input logic [15:0] l, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1) return (s % 2 != 0) || (d % 2 != 0) || (l % 2 != 0);
    if (sz == 2'd2) return (s % 4 != 0) || (d % 4 != 0) || (l % 4 != 0);
    return 1'b0;
  endfunction

  // mode 0: no stalls, 1: stall where mask[cycle] is set, 2: random stalls and
  // random start pulses while busy. Cycle 1 is the first cycle after the start edge.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] len,
                          input logic [1:0] sz, input int mode, input logic [31:0] mask,
                          input logic exp_err, input int exp_n, input string tag);
    int   cyc, stalls, busy_cnt, wr_base, exp_cyc;
    logic seen_done, seen_err, mb;
    wr_base = wr_count;
    if (!exp_err)
      for (int b = 0; b < int'(len); b++) ref_mem[d + 32'(b)] = ref_rd8(s + 32'(b));

    @(negedge clk);
    src_addr = s; dst_addr = d; length = len; size = sz; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src_addr = $urandom; dst_addr = $urandom; length = 16'($urandom); size = 2'($urandom);
    cyc = 1; stalls = 0; busy_cnt = 0; seen_done = 1'b0; seen_err = 1'b0;
    while (cyc < 400) begin
      if (busy) busy_cnt++;
      if (done || error) begin
        seen_done = done; seen_err = error;
        mem_busy = 1'b0; start = 1'b0;
        break;
      end
      case (mode)
        1:       mb = (cyc < 32) ? mask[cyc] : 1'b0;
        2:       mb = ($urandom_range(0, 3) == 0);
        default: mb = 1'b0;
      endcase
      mem_busy = mb;
      if (mb) stalls++;
      if (mode == 2) start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      cyc++;
    end
    mem_busy = 1'b0; start = 1'b0;
    chk({tag, ".completed"}, 32'(seen_done | seen_err), 32'd1);

    exp_cyc = (exp_err || exp_n == 0) ? 1 : 1 + 2 * exp_n + stalls;
    chk({tag, ".error"}, 32'(seen_err), 32'(exp_err));
    chk({tag, ".done"}, 32'(seen_done), 32'(!exp_err));
    chk({tag, ".end_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_cyc));
    chk({tag, ".writes"}, 32'(wr_count - wr_base), 32'(exp_n));
    if (!exp_err && exp_n > 0) chk({tag, ".bytes_done"}, {16'h0, bytes_done}, {16'h0, len});

    if (!(seen_done || seen_err)) begin
      reset = 1'b1; @(negedge clk); reset = 1'b0;
    end
    @(negedge clk);
    chk({tag, ".idle_after"}, {25'h0, busy, done, error, 1'b0, mem_funct3}, {25'h0, 3'b000, 1'b0, 3'b010});
    cmp_mem(tag);
    $display("copy %s src=%h dst=%h len=%0d size=%0d end_cycle=%0d stalls=%0d writes=%0d",
             tag, s, d, len, sz, cyc, stalls, wr_count - wr_base);
  endtask

  // ---------------- stimulus table ----------------------------------------
  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic [1:0]  sz;
    logic [31:0] mask;
    logic        exp_err;
    int          exp_n;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s, d;
    logic [15:0] l;
    logic [1:0]  sz;
    int          n, p;
    logic        e;

    vecs[0] = '{32'h0000_0100, 32'h0000_0200, 16'd16, 2'd2, 32'h0,  1'b0, 4}; // word copy
    vecs[1] = '{32'h0000_0141, 32'h0000_0241, 16'd3,  2'd0, 32'h0,  1'b0, 3}; // byte copy
    vecs[2] = '{32'h0000_0300, 32'hFFFF_FFFC, 16'd4,  2'd2, 32'h0,  1'b0, 1}; // LED register
    vecs[3] = '{32'h0000_0102, 32'h0000_0900, 16'd4,  2'd2, 32'h0,  1'b1, 0}; // misaligned src
    vecs[4] = '{32'h0000_0100, 32'h0000_0900, 16'd0,  2'd2, 32'h0,  1'b0, 0}; // zero length
    vecs[5] = '{32'h0000_0400, 32'h0000_0500, 16'd8,  2'd2, 32'h1C, 1'b0, 2}; // 3-cycle WRITE stall
    vecs[6] = '{32'h0000_0100, 32'h0000_0900, 16'd4,  2'd3, 32'h0,  1'b1, 0}; // illegal size
    vecs[7] = '{32'h0000_0100, 32'h0000_0901, 16'd4,  2'd1, 32'h0,  1'b1, 0}; // misaligned dst
    vecs[8] = '{32'h0000_0100, 32'h0000_0900, 16'd3,  2'd1, 32'h0,  1'b1, 0}; // odd half length
    vecs[9] = '{32'h0000_0102, 32'h0000_0602, 16'd6,  2'd1, 32'h2,  1'b0, 3}; // half copy, READ stall

    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0; size = '0;
    mem_busy = 1'b0;

    poke32(32'h100, 32'h1111_1111); poke32(32'h104, 32'h2222_2222);
    poke32(32'h108, 32'h3333_3333); poke32(32'h10C, 32'h4444_4444);
    poke32(32'h140, 32'hA1B2_C3D4); poke32(32'h240, 32'hFFFF_FFFF);
    poke32(32'h244, 32'h0000_005A);
    poke32(32'h300, 32'h80FF_0040);
    poke32(32'h400, 32'hDEAD_BEEF); poke32(32'h404, 32'hCAFE_F00D);
    poke32(32'h500, 32'h5555_5555); poke32(32'h504, 32'h6666_6666);
    poke32(32'h600, 32'h7777_7777); poke32(32'h604, 32'h7777_7777);
    for (int a = 32'h1000; a < 32'h1800; a += 4) poke32(32'(a), $urandom);
    for (int a = 32'h700; a < 32'h710; a += 4) poke32(32'(a), $urandom);

    // Reset state, sampled while reset is held and after release.
    repeat (3) @(negedge clk);
    chk("reset.busy_done_error", {29'h0, busy, done, error}, 32'h0);
    chk("reset.mem_write_mem", {31'h0, mem_write_mem}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("reset.bytes_done", {16'h0, bytes_done}, 32'h0);
    chk("reset.funct3", {29'h0, mem_funct3}, 32'h2);
    chk("reset.read_address", mem_read_address, 32'h0);
    chk("reset.write_address", mem_write_address, 32'h0);
    chk("reset.write_data", mem_write_data, 32'h0);

    for (int i = 0; i < 10; i++)
      run_copy(vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].sz, 1, vecs[i].mask,
               vecs[i].exp_err, vecs[i].exp_n, $sformatf("vec%0d", i));

    chk("byte_copy.dst_word", peek32(32'h240), 32'hA1B2_C3FF);
    chk("byte_copy.next_byte", {24'h0, mem_rd8(32'h244)}, 32'h5A);
    chk("led.reg", peek32(32'hFFFF_FFFC), 32'h80FF_0040);
    chk("led.duty", {24'h0, mem_rd8(32'hFFFF_FFFF)}, 32'h80);

    // Reset during the second WRITE of a 4-word copy.
    begin
      int wr_base;
      wr_base = wr_count;
      @(negedge clk);
      src_addr = 32'h700; dst_addr = 32'h800; length = 16'd16; size = 2'd2; start = 1'b1;
      @(negedge clk); start = 1'b0;          // cycle 1: READ
      repeat (3) @(negedge clk);             // cycle 4: second WRITE
      chk("rst_mid.busy_before", {31'h0, busy}, 32'h1);
      reset = 1'b1;
      #1;
      chk("rst_mid.write_gated", {31'h0, mem_write_mem}, 32'h0);
      @(negedge clk);
      chk("rst_mid.busy", {31'h0, busy}, 32'h0);
      chk("rst_mid.bytes_done", {16'h0, bytes_done}, 32'h0);
      chk("rst_mid.read_address", mem_read_address, 32'h0);
      chk("rst_mid.writes", 32'(wr_count - wr_base), 32'd1);
      reset = 1'b0;
      for (int b = 0; b < 4; b++) ref_mem[32'h800 + 32'(b)] = ref_rd8(32'h700 + 32'(b));
      cmp_mem("rst_mid");
      $display("copy rst_mid src=00000700 dst=00000800 len=16 size=2 writes=%0d", wr_count - wr_base);
      run_copy(32'h700, 32'h800, 16'd16, 2'd2, 0, 32'h0, 1'b0, 4, "after_reset");
    end

    // Randomized copies with random stalls and ignored start pulses.
    for (int it = 0; it < 25; it++) begin
      sz = 2'($urandom_range(0, 2));
      n  = $urandom_range(1, 8);
      s  = (32'h1000 + 32'($urandom_range(0, 32'hEC0))) & ~((32'd1 << sz) - 32'd1);
      d  = 32'h3000 + 32'(it) * 32'h40;
      l  = 16'(n << sz);
      p  = $urandom_range(0, 9);
      case (p)
        0: sz = 2'd3;
        1: s  = s ^ 32'd1;
        2: l  = l + 16'd1;
        3: d  = d | 32'd2;
        default: ;
      endcase
      e = rule_reject(s, d, l, sz);
      run_copy(s, d, l, sz, 2, 32'h0, e, e ? 0 : int'(l) / (1 << sz), $sformatf("rnd%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
